// File: rtl/gate_lane_arbiter.sv
// Shares one barrier actuator between the entry and exit lanes: arbitrates the lanes,
// sequences open / wait-for-pass / close, and tracks lot occupancy.
module gate_lane_arbiter #(
   parameter int CAPACITY     = 16,
   parameter int CNT_W        = 5,
   parameter int OPEN_CYCLES  = 8,
   parameter int PASS_TIMEOUT = 64,
   parameter int TO_W         = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             entry_clear,
   input  logic             exit_clear,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic             gate_open_cmd,
   output logic             gate_close_cmd,
   output logic             busy,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             timeout_alarm
);

   // One phase counter serves both actuator travel and the pass timeout.
   localparam int PH_W = (TO_W > $clog2(OPEN_CYCLES + 1)) ? TO_W : $clog2(OPEN_CYCLES + 1);
   localparam logic [PH_W-1:0]  OPEN_LAST = PH_W'(OPEN_CYCLES - 1);
   localparam logic [PH_W-1:0]  PASS_LAST = PH_W'(PASS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
   localparam logic             LANE_ENTRY = 1'b0;
   localparam logic             LANE_EXIT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      OPENING   = 2'd1,
      WAIT_PASS = 2'd2,
      CLOSING   = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic              lane_r, lane_s;
   logic              last_r, last_s;
   logic [PH_W-1:0]   cnt_r, cnt_s;
   logic [CNT_W-1:0]  occ_s;
   logic              alarm_s;
   logic              entry_elig_s, exit_elig_s, sel_s, clear_s;

   assign full  = (occupancy == CAP_V);
   assign empty = (occupancy == {CNT_W{1'b0}});

   // Next-state, lane selection, occupancy update and timeout detection.
   always_comb begin
      state_s      = state_r;
      lane_s       = lane_r;
      last_s       = last_r;
      cnt_s        = cnt_r;
      occ_s        = occupancy;
      alarm_s      = 1'b0;
      entry_elig_s = entry_req & ~full;
      exit_elig_s  = exit_req & ~empty;
      // Round-robin only matters when both lanes are eligible.
      sel_s        = (entry_elig_s & exit_elig_s) ? ~last_r : exit_elig_s;
      clear_s      = (lane_r == LANE_EXIT) ? exit_clear : entry_clear;
      case (state_r)
         IDLE: begin
            cnt_s = {PH_W{1'b0}};
            if (entry_elig_s | exit_elig_s) begin
               state_s = OPENING;
               lane_s  = sel_s;
               last_s  = sel_s;
            end else begin
               state_s = IDLE;
            end
         end
         OPENING: begin
            if (cnt_r == OPEN_LAST) begin
               state_s = WAIT_PASS;
               cnt_s   = {PH_W{1'b0}};
            end else begin
               cnt_s = cnt_r + PH_W'(1);
            end
         end
         WAIT_PASS: begin
            if (clear_s) begin
               state_s = CLOSING;
               cnt_s   = {PH_W{1'b0}};
               if (lane_r == LANE_ENTRY) begin
                  if (occupancy != CAP_V) begin
                     occ_s = occupancy + CNT_W'(1);
                  end else begin
                     occ_s = occupancy;
                  end
               end else begin
                  if (occupancy != {CNT_W{1'b0}}) begin
                     occ_s = occupancy - CNT_W'(1);
                  end else begin
                     occ_s = occupancy;
                  end
               end
            end else if (cnt_r == PASS_LAST) begin
               state_s = CLOSING;
               cnt_s   = {PH_W{1'b0}};
               alarm_s = 1'b1;
            end else begin
               cnt_s = cnt_r + PH_W'(1);
            end
         end
         CLOSING: begin
            if (cnt_r == OPEN_LAST) begin
               state_s = IDLE;
               cnt_s   = {PH_W{1'b0}};
            end else begin
               cnt_s = cnt_r + PH_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {PH_W{1'b0}};
         end
      endcase
   end

   // State, occupancy and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         lane_r         <= LANE_ENTRY;
         last_r         <= LANE_EXIT;
         cnt_r          <= {PH_W{1'b0}};
         occupancy      <= {CNT_W{1'b0}};
         entry_grant    <= 1'b0;
         exit_grant     <= 1'b0;
         gate_open_cmd  <= 1'b0;
         gate_close_cmd <= 1'b0;
         busy           <= 1'b0;
         timeout_alarm  <= 1'b0;
      end else begin
         state_r        <= state_s;
         lane_r         <= lane_s;
         last_r         <= last_s;
         cnt_r          <= cnt_s;
         occupancy      <= occ_s;
         entry_grant    <= (state_s != IDLE) && (lane_s == LANE_ENTRY);
         exit_grant     <= (state_s != IDLE) && (lane_s == LANE_EXIT);
         gate_open_cmd  <= (state_s == OPENING);
         gate_close_cmd <= (state_s == CLOSING);
         busy           <= (state_s != IDLE);
         timeout_alarm  <= alarm_s;
      end
   end

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Scoreboard bench for gate_lane_arbiter: stimulus queues expected transactions,
// a negedge monitor reassembles each grant window and compares it.
module tb_gate_lane_arbiter;

   localparam int CAPACITY     = 2;
   localparam int CNT_W        = 2;
   localparam int OPEN_CYCLES  = 3;
   localparam int PASS_TIMEOUT = 10;
   localparam int TO_W         = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             entry_req = 1'b0, exit_req = 1'b0;
   logic             entry_clear = 1'b0, exit_clear = 1'b0;
   logic             entry_grant, exit_grant, gate_open_cmd, gate_close_cmd, busy;
   logic [CNT_W-1:0] occupancy;
   logic             full, empty, timeout_alarm;

   gate_lane_arbiter #(
      .CAPACITY(CAPACITY), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN_CYCLES),
      .PASS_TIMEOUT(PASS_TIMEOUT), .TO_W(TO_W)
   ) dut (
      .clk(clk), .rst(rst),
      .entry_req(entry_req), .exit_req(exit_req),
      .entry_clear(entry_clear), .exit_clear(exit_clear),
      .entry_grant(entry_grant), .exit_grant(exit_grant),
      .gate_open_cmd(gate_open_cmd), .gate_close_cmd(gate_close_cmd),
      .busy(busy), .occupancy(occupancy), .full(full), .empty(empty),
      .timeout_alarm(timeout_alarm)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int lane;
      int start;
      int wait_len;
      int close_len;
      int alarm;
      int occ;
   } txn_t;

   txn_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   idle_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_txn(input int lane, input int start, input int wait_len,
                             input int close_len, input int alarm, input int occ);
      txn_t e;
      e.lane = lane; e.start = start; e.wait_len = wait_len;
      e.close_len = close_len; e.alarm = alarm; e.occ = occ;
      exp_q.push_back(e);
   endtask

   // Monitor: accumulate one grant window, compare when the grant drops.
   int in_txn = 0;
   int c_lane, c_start, c_open, c_wait, c_close, c_alarm, c_bad;
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         if (entry_grant || exit_grant) begin
            if (in_txn == 0) begin
               in_txn = 1; c_lane = int'(exit_grant); c_start = cyc;
               c_open = 0; c_wait = 0; c_close = 0; c_alarm = 0; c_bad = 0;
            end
            if (entry_grant && exit_grant) c_bad++;
            if (gate_open_cmd && gate_close_cmd) c_bad++;
            if (int'(exit_grant) != c_lane) c_bad++;
            if (!busy) c_bad++;
            if (gate_open_cmd && (c_wait + c_close) != 0) c_bad++;
            if (!gate_open_cmd && !gate_close_cmd && c_close != 0) c_bad++;
            if (gate_open_cmd) c_open++;
            else if (gate_close_cmd) c_close++;
            else c_wait++;
            if (timeout_alarm) c_alarm++;
         end else if (in_txn != 0) begin
            in_txn = 0;
            chk("txn_pending", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("txn_lane", c_lane, e.lane);
               chk("txn_start", c_start, e.start);
               chk("txn_open_len", c_open, OPEN_CYCLES);
               chk("txn_wait_len", c_wait, e.wait_len);
               chk("txn_close_len", c_close, e.close_len);
               chk("txn_alarm", c_alarm, e.alarm);
               chk("txn_occ_after", int'(occupancy), e.occ);
               chk("txn_protocol", c_bad, 0);
            end
         end else begin
            if (busy === 1'b1 || gate_open_cmd === 1'b1 || gate_close_cmd === 1'b1 ||
                timeout_alarm === 1'b1) idle_bad++;
         end
      end
   end

   int b, t, t2, t3, s1, s2, s3, r;
   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      b = cyc + 2;
      goto(b);
      chk("rst_entry_grant", int'(entry_grant), 0);
      chk("rst_exit_grant", int'(exit_grant), 0);
      chk("rst_open", int'(gate_open_cmd), 0);
      chk("rst_close", int'(gate_close_cmd), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_alarm", int'(timeout_alarm), 0);
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);

      // Exit refused while the lot is empty.
      exit_req = 1'b1;
      goto(b + 5);
      chk("empty_no_grant", int'(entry_grant | exit_grant), 0);
      chk("empty_busy", int'(busy), 0);
      chk("empty_flag", int'(empty), 1);
      exit_req = 1'b0;

      // Basic entry with ignored clears (during opening, and wrong lane).
      t = b + 10;
      goto(t);
      entry_req = 1'b1;
      expect_txn(0, t + 1, 3, 3, 0, 1);
      goto(t + 1); entry_req = 1'b0;
      goto(t + 2); entry_clear = 1'b1;
      goto(t + 3); entry_clear = 1'b0;
      goto(t + 5); exit_clear = 1'b1;
      goto(t + 6); exit_clear = 1'b0; entry_clear = 1'b1;
      goto(t + 7); entry_clear = 1'b0;

      // Second entry fills the lot; clear on first wait cycle.
      t2 = t + 12;
      goto(t2);
      entry_req = 1'b1;
      expect_txn(0, t2 + 1, 1, 3, 0, 2);
      goto(t2 + 1); entry_req = 1'b0;
      goto(t2 + 4); entry_clear = 1'b1;
      goto(t2 + 5); entry_clear = 1'b0;

      // Full: entry held but refused; an exit frees it.
      t3 = t2 + 9;
      goto(t3);
      entry_req = 1'b1;
      goto(t3 + 5);
      chk("full_no_grant", int'(entry_grant | exit_grant), 0);
      chk("full_flag", int'(full), 1);
      chk("full_occ", int'(occupancy), 2);
      chk("full_busy", int'(busy), 0);
      exit_req = 1'b1;
      expect_txn(1, t3 + 6, 1, 3, 0, 1);
      goto(t3 + 9); exit_clear = 1'b1;
      goto(t3 + 10); exit_clear = 1'b0;

      // Both held at occupancy 1: entry (timeout), exit (timeout), entry (clear on last cycle).
      s1 = t3 + 14;
      s2 = s1 + 17;
      s3 = s2 + 17;
      expect_txn(0, s1, 10, 3, 1, 1);
      expect_txn(1, s2, 10, 3, 1, 1);
      expect_txn(0, s3, 10, 3, 0, 2);
      goto(s3 + 1); entry_req = 1'b0; exit_req = 1'b0;
      goto(s3 + 12); entry_clear = 1'b1;
      goto(s3 + 13); entry_clear = 1'b0;

      // Reset during WAIT_PASS aborts the exit transaction.
      r = s3 + 18;
      goto(r);
      exit_req = 1'b1;
      expect_txn(1, r + 1, 3, 0, 0, 0);
      goto(r + 1); exit_req = 1'b0;
      goto(r + 4); entry_clear = 1'b1;
      goto(r + 5); entry_clear = 1'b0;
      goto(r + 6); rst = 1'b1;
      goto(r + 7); rst = 1'b0;
      chk("abort_grant", int'(entry_grant | exit_grant), 0);
      chk("abort_occ", int'(occupancy), 0);
      goto(r + 8);
      chk("abort_busy", int'(busy), 0);
      chk("abort_cmds", int'(gate_open_cmd | gate_close_cmd | timeout_alarm), 0);
      chk("abort_empty", int'(empty), 1);

      goto(r + 12);
      chk("queue_drained", exp_q.size(), 0);
      chk("idle_outputs_quiet", idle_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
